// File: rtl/serial_subtractor32_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor32.
// Flag signals ovf/zero exist only when SUB_FLAGS_EN is defined.
interface serial_subtractor32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_FLAGS_EN
    logic             ovf;
    logic             zero;
`endif

`ifdef SUB_FLAGS_EN
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );
    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor32.sv
// Multi-cycle subtractor: {bout,diff} = a - b - bin, CHUNK bits per clock.
// Define SUB_FLAGS_EN to add signed-overflow and zero flags.
module serial_subtractor32 #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor32_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    ctr_q, ctr_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic [CHUNK:0]   sub;
    logic             last;
`ifdef SUB_FLAGS_EN
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
`endif

    always_comb begin
        sub = {1'b0, a_q[CHUNK-1:0]}
            - {1'b0, b_q[CHUNK-1:0]}
            - {{CHUNK{1'b0}}, brw_q};
        last    = (ctr_q == CW'(N - 1));
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        ctr_d   = ctr_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
`ifdef SUB_FLAGS_EN
        ovf_d   = ovf_q;
        zero_d  = zero_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    res_d   = '0;
                    ctr_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                brw_d = sub[CHUNK];
                res_d = {sub[CHUNK-1:0], res_q[WIDTH-1:CHUNK]};
                ctr_d = ctr_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    diff_d  = res_d;
                    bout_d  = sub[CHUNK];
`ifdef SUB_FLAGS_EN
                    // On the last chunk the low bits of a_q/b_q hold the operand MSBs.
                    ovf_d  = (a_q[CHUNK-1] != b_q[CHUNK-1])
                           && (sub[CHUNK-1] != a_q[CHUNK-1]);
                    zero_d = (res_d == '0);
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            ctr_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SUB_FLAGS_EN
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            ctr_q   <= ctr_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
`ifdef SUB_FLAGS_EN
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SUB_FLAGS_EN
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_serial_subtractor32.sv
// Directed bench for serial_subtractor32 (WIDTH=32, CHUNK=4).
// Flag checks are compiled in when SUB_FLAGS_EN is defined.
module tb_serial_subtractor32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    logic [31:0] prev_diff = '0;
    logic        prev_bout = 1'b0;

    serial_subtractor32_if #(.WIDTH(32)) sif ();

    serial_subtractor32 #(.WIDTH(32), .CHUNK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tbin, input logic [31:0] ed,
                          input logic eb, input logic eo, input int poke);
        int cyc;
        int busy_n;
        int hold_bad;
        bit seen;
        sif.start = 1'b1;
        sif.a     = ta;
        sif.b     = tb_;
        sif.bin   = tbin;
        tick();
        sif.start = 1'b0;
        sif.a     = $urandom;
        sif.b     = $urandom;
        sif.bin   = 1'b1;
        cyc = 0; busy_n = 0; hold_bad = 0; seen = 0;
        while (!seen && cyc < 20) begin
            if (sif.done) begin
                seen = 1;
            end else begin
                if (sif.busy) busy_n++;
                if (sif.diff !== prev_diff || sif.bout !== prev_bout)
                    hold_bad++;
                if (cyc == poke) begin
                    sif.start = 1'b1;
                    sif.a     = 32'd0;
                    sif.b     = 32'd0;
                end else begin
                    sif.start = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        chk("latency", seen ? cyc : -1, 32'd8);
        chk("busy_cycles", busy_n, 32'd8);
        chk("hold_prev", hold_bad, 32'd0);
        chk("busy_in_done", {31'd0, sif.busy}, 32'd0);
        chk("diff", sif.diff, ed);
        chk("bout", {31'd0, sif.bout}, {31'd0, eb});
`ifdef SUB_FLAGS_EN
        chk("ovf", {31'd0, sif.ovf}, {31'd0, eo});
        chk("zero", {31'd0, sif.zero}, {31'd0, (ed == 32'd0)});
`else
        if (eo) begin end
`endif
        tick();
        chk("done_pulse", {31'd0, sif.done}, 32'd0);
        chk("idle_after", {31'd0, sif.busy}, 32'd0);
        chk("diff_kept", sif.diff, ed);
        prev_diff = ed;
        prev_bout = eb;
    endtask

    initial begin
        int cyc;
        int d1;
        int d2;
        int nd;
        int bad;
        sif.start = 1'b0;
        sif.a     = '0;
        sif.b     = '0;
        sif.bin   = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, sif.busy}, 32'd0);
        chk("rst_done", {31'd0, sif.done}, 32'd0);
        chk("rst_diff", sif.diff, 32'd0);
        chk("rst_bout", {31'd0, sif.bout}, 32'd0);
`ifdef SUB_FLAGS_EN
        chk("rst_ovf", {31'd0, sif.ovf}, 32'd0);
        chk("rst_zero", {31'd0, sif.zero}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        run_op(32'd10, 32'd3, 1'b0, 32'd7, 1'b0, 1'b0, -1);
        run_op(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
        run_op(32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
        run_op(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, -1);
        run_op(32'd9, 32'd9, 1'b0, 32'd0, 1'b0, 1'b0, -1);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1,
               32'h7777_7787, 1'b1, 1'b0, -1);
        run_op(32'h0001_0000, 32'd1, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, -1);
        // start pulsed mid-run with new operands must be ignored
        run_op(32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 3);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (sif.done || sif.busy) nd++;
            tick();
        end
        chk("no_queued_op", nd, 32'd0);

        // reset in the 4th RUN cycle
        sif.start = 1'b1;
        sif.a     = 32'h0000_1000;
        sif.b     = 32'd1;
        sif.bin   = 1'b0;
        tick();
        sif.start = 1'b0;
        tick();
        tick();
        tick();
        chk("run_before_rst", {31'd0, sif.busy}, 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_busy", {31'd0, sif.busy}, 32'd0);
        chk("abort_diff", sif.diff, 32'd0);
        chk("abort_bout", {31'd0, sif.bout}, 32'd0);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (sif.done) nd++;
            tick();
        end
        chk("abort_no_done", nd, 32'd0);
        prev_diff = '0;
        prev_bout = 1'b0;
        run_op(32'd20, 32'd7, 1'b0, 32'd13, 1'b0, 1'b0, -1);

        // start held high: two ops back to back
        sif.start = 1'b1;
        sif.a     = 32'd1000;
        sif.b     = 32'd1;
        sif.bin   = 1'b0;
        tick();
        sif.a = 32'd50;
        sif.b = 32'd8;
        d1 = -1; d2 = -1; bad = 0; cyc = 0;
        while (d2 < 0 && cyc < 40) begin
            if (sif.done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    chk("b2b_first", sif.diff, 32'd999);
                end else begin
                    d2 = cyc;
                    sif.start = 1'b0;
                end
            end else if (d1 >= 0 && sif.diff !== 32'd999) begin
                bad++;
            end
            if (d2 < 0) begin
                tick();
                cyc++;
            end
        end
        chk("b2b_first_at", d1, 32'd8);
        chk("b2b_spacing", d2 - d1, 32'd10);
        chk("b2b_hold", bad, 32'd0);
        chk("b2b_second", sif.diff, 32'd42);
        sif.start = 1'b0;
        tick();
        chk("b2b_idle", {31'd0, sif.busy | sif.done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule
